// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
//   dmem_req   : request, held until dmem_ack
//   dmem_we    : 1 = write
//   dmem_addr  : word-aligned byte address
//   dmem_be    : byte enables, bit i = byte lane i (little-endian)
//   dmem_wdata : lane-replicated store data
//   dmem_rdata : read data, valid with dmem_ack
//   dmem_ack   : access complete
// master = MEM stage, slave = memory.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit.
// Turns the EX/MEM load/store into one req/ack bus transaction, formats load data
// for MEM/WB, stalls the pipeline while the access is outstanding, flags misaligned
// accesses and times out a memory that never acknowledges.
// Ports:
//   clock, reset              : clock, asynchronous active-high reset
//   alu_addr, store_data      : byte address and rt data from EX/MEM
//   mem_rd, mem_wr            : load / store (both set = store)
//   mem_size, mem_unsigned    : 00 byte, 01 half, 1x word; zero-extend loads
//   dmem                      : data-memory bus (master side)
//   readdata_out              : formatted load result, held between loads
//   mem_stall                 : hold the front of the pipeline
//   misaligned, bus_err       : one-cycle event pulses
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [31:0]                alu_addr,
  input  logic [31:0]                store_data,
  input  logic                       mem_rd,
  input  logic                       mem_wr,
  input  logic [1:0]                 mem_size,
  input  logic                       mem_unsigned,
  mem_access_stage_if.master         dmem,
  output logic [31:0]                readdata_out,
  output logic                       mem_stall,
  output logic                       misaligned,
  output logic                       bus_err
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             mis_q, mis_d;
  logic             err_q, err_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  // Load formatting context captured at issue so it does not depend on EX/MEM.
  logic [1:0]       off_q, off_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;

  logic             access, aligned;
  logic [3:0]       be_fmt;
  logic [31:0]      wdata_fmt, load_fmt;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;

  assign access = mem_rd | mem_wr;

  always_comb begin
    aligned   = 1'b1;
    be_fmt    = 4'b1111;
    wdata_fmt = store_data;
    unique case (mem_size)
      2'b00: begin
        be_fmt    = 4'b0001 << alu_addr[1:0];
        wdata_fmt = {4{store_data[7:0]}};
      end
      2'b01: begin
        aligned   = ~alu_addr[0];
        be_fmt    = alu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{store_data[15:0]}};
      end
      default: aligned = (alu_addr[1:0] == 2'b00);
    endcase
  end

  always_comb begin
    lane_b   = dmem.dmem_rdata[{off_q, 3'b000} +: 8];
    lane_h   = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    load_fmt = dmem.dmem_rdata;
    unique case (size_q)
      2'b00:   load_fmt = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'b01:   load_fmt = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: load_fmt = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    unique case (state_q)
      StIdle: begin
        if (access && aligned) begin
          addr_d  = {alu_addr[31:2], 2'b00};
          we_d    = mem_wr;
          be_d    = be_fmt;
          wdata_d = wdata_fmt;
          off_d   = alu_addr[1:0];
          size_d  = mem_size;
          uns_d   = mem_unsigned;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = StBusy;
        end else if (access) begin
          mis_d = 1'b1;
        end
      end
      StBusy: begin
        cnt_d = cnt_q + TO_W'(1);
        if (dmem.dmem_ack) begin
          req_d = 1'b0;
          if (!we_q) rdata_d = load_fmt;
          state_d = StDone;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          // TIMEOUT request cycles have elapsed without an acknowledge.
          req_d   = 1'b0;
          err_d   = 1'b1;
          if (!we_q) rdata_d = 32'h0000_0000;
          state_d = StDone;
        end
      end
      // One unstalled cycle lets EX/MEM advance so the access is never reissued.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;
  assign readdata_out    = rdata_q;
  assign misaligned      = mis_q;
  assign bus_err         = err_q;

  // Masked by reset so the stall drops immediately even if EX/MEM still holds an access.
  assign mem_stall = ~reset &
                     (((state_q == StIdle) & access & aligned) | (state_q == StBusy));

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  localparam int unsigned Timeout = 4;

  typedef struct {
    bit          mis;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          tmo;
    int          ncyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] alu_addr, store_data;
  logic        mem_rd, mem_wr, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] readdata_out;
  logic        mem_stall, misaligned, bus_err;

  mem_access_stage_if dmem_bus ();

  mem_access_stage #(.TIMEOUT(Timeout), .TO_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .alu_addr     (alu_addr),
    .store_data   (store_data),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .dmem         (dmem_bus),
    .readdata_out (readdata_out),
    .mem_stall    (mem_stall),
    .misaligned   (misaligned),
    .bus_err      (bus_err)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] bus_mem [0:255];
  logic [31:0] last_rd = 32'h0;
  int          mem_lat = 1;     // request cycles up to and including the ack; 0 = never
  logic        spur_ack = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, want);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event not expected or missing", nm);
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    bus_mem[a[9:2]] = w;
    for (int k = 0; k < 4; k++) ref_mem[int'({a[9:2], 2'b00}) + k] = w[8*k +: 8];
  endtask

  // Memory slave: acks on the mem_lat-th request cycle, garbage rdata otherwise.
  initial begin : responder
    int busy;
    logic [7:0] idx;
    busy = 0;
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    forever begin
      @(posedge clock);
      #1;
      dmem_bus.dmem_ack   = spur_ack;
      dmem_bus.dmem_rdata = $urandom;
      if (dmem_bus.dmem_req && !reset) begin
        busy++;
        if (mem_lat != 0 && busy == mem_lat) begin
          idx = dmem_bus.dmem_addr[9:2];
          dmem_bus.dmem_ack   = 1'b1;
          dmem_bus.dmem_rdata = bus_mem[idx];
          if (dmem_bus.dmem_we)
            for (int b = 0; b < 4; b++)
              if (dmem_bus.dmem_be[b]) bus_mem[idx][8*b +: 8] = dmem_bus.dmem_wdata[8*b +: 8];
          busy = 0;
        end
      end else begin
        busy = 0;
      end
    end
  end

  // Monitor: pops an expectation when a request starts or a misaligned pulse appears.
  initial begin : monitor
    exp_t cur;
    exp_t e;
    bit   active;
    bit   prev_req;
    int   ncyc;
    active = 0;
    prev_req = 0;
    ncyc = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        active = 0;
        prev_req = 0;
        ncyc = 0;
        continue;
      end
      if (misaligned) begin
        if (exp_q.size() == 0) fail("misaligned_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("misaligned_expected", 32'(misaligned), 32'(e.mis));
          chk("misaligned_readdata", readdata_out, e.rdata);
        end
      end
      if (dmem_bus.dmem_req) begin
        if (!prev_req) begin
          if (exp_q.size() == 0) fail("req_unexpected");
          else begin
            cur = exp_q.pop_front();
            active = 1;
            ncyc = 0;
            chk("req_not_misaligned", 32'(cur.mis), 32'(1'b0));
          end
        end
        if (active) begin
          chk("dmem_addr", dmem_bus.dmem_addr, cur.addr);
          chk("dmem_we", 32'(dmem_bus.dmem_we), 32'(cur.we));
          chk("dmem_be", 32'(dmem_bus.dmem_be), 32'(cur.be));
          chk("dmem_wdata", dmem_bus.dmem_wdata, cur.wdata);
          chk("stall_in_busy", 32'(mem_stall), 32'(1'b1));
        end
        ncyc++;
      end else if (prev_req && active) begin
        chk("req_cycles", 32'(ncyc), 32'(cur.ncyc));
        chk("bus_err", 32'(bus_err), 32'(cur.tmo));
        chk("readdata", readdata_out, cur.rdata);
        chk("stall_released", 32'(mem_stall), 32'(1'b0));
        active = 0;
      end else if (bus_err) begin
        fail("bus_err_spurious");
      end
      prev_req = dmem_bus.dmem_req;
    end
  end

  // Reference model: computes the expected transaction from the byte-level rules,
  // then presents the instruction and waits until the pipeline advances.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] sd, input int lat,
                       input bit no_wait = 0);
    exp_t e;
    int n, off, stalls, want_stalls, base;
    logic st;
    longint unsigned v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    base = int'(a[9:0]);
    e = '{default: 0};
    e.rdata = last_rd;
    e.mis = (off % n) != 0;
    want_stalls = 0;
    if ((rd || wr) && e.mis) begin
      exp_q.push_back(e);
    end else if (rd || wr) begin
      e.we   = wr;
      e.addr = {a[31:2], 2'b00};
      e.tmo  = (lat == 0) || (lat > int'(Timeout));
      e.ncyc = e.tmo ? int'(Timeout) : lat;
      for (int k = 0; k < 4; k++) begin
        e.wdata[8*k +: 8] = sd[8*(k % n) +: 8];
        e.be[k] = (k >= off) && (k < off + n);
      end
      if (wr) begin
        if (!e.tmo) for (int i = 0; i < n; i++) ref_mem[base + i] = sd[8*i +: 8];
      end else begin
        v = 0;
        if (!e.tmo) begin
          for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[base + i]) << (8 * i));
          if (!uns && v[8*n-1]) v = v - (64'd1 << (8 * n));
        end
        last_rd = v[31:0];
        e.rdata = last_rd;
      end
      want_stalls = e.ncyc + 1;
      exp_q.push_back(e);
    end
    mem_lat      = lat;
    mem_rd       = rd;
    mem_wr       = wr;
    mem_size     = sz;
    mem_unsigned = uns;
    alu_addr     = a;
    store_data   = sd;
    if (no_wait) return;
    stalls = 0;
    forever begin
      @(negedge clock);
      st = mem_stall;
      @(posedge clock);
      #2;
      if (!st) break;
      stalls++;
      if (stalls > 40) begin
        fail("stall_never_released");
        break;
      end
    end
    chk("stall_cycles", 32'(stalls), 32'(want_stalls));
  endtask

  task automatic idle(input int cyc);
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    repeat (cyc) @(posedge clock);
    #2;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      set_word(32'(i * 4), w);
    end
    reset = 1'b1;
    alu_addr = '0;
    store_data = '0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    mem_size = 2'b00;
    mem_unsigned = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_req", 32'(dmem_bus.dmem_req), 32'(1'b0));
    chk("reset_we", 32'(dmem_bus.dmem_we), 32'(1'b0));
    chk("reset_addr", dmem_bus.dmem_addr, 32'h0);
    chk("reset_be", 32'(dmem_bus.dmem_be), 32'h0);
    chk("reset_wdata", dmem_bus.dmem_wdata, 32'h0);
    chk("reset_readdata", readdata_out, 32'h0);
    chk("reset_misaligned", 32'(misaligned), 32'(1'b0));
    chk("reset_bus_err", 32'(bus_err), 32'(1'b0));
    reset = 1'b0;
    @(posedge clock);
    #2;

    // Directed cases.
    set_word(32'h100, 32'h80FF_1234);
    issue(1, 0, 2'b00, 0, 32'h103, 32'h0, 1);          // LB  -> FFFFFF80
    idle(1);
    chk("lb_value", readdata_out, 32'hFFFF_FF80);
    issue(1, 0, 2'b00, 1, 32'h103, 32'h0, 1);          // LBU -> 00000080
    idle(1);
    chk("lbu_value", readdata_out, 32'h0000_0080);
    issue(0, 1, 2'b01, 0, 32'h206, 32'h1234_ABCD, 4);  // SH, ack on last legal cycle
    issue(1, 0, 2'b10, 0, 32'h302, 32'h0, 1);          // misaligned LW
    issue(1, 0, 2'b01, 0, 32'h301, 32'h0, 1);          // misaligned LH
    issue(1, 0, 2'b10, 0, 32'h100, 32'h0, 0);          // LW, no ack -> timeout
    issue(1, 1, 2'b10, 0, 32'h040, $urandom, 1);       // rd+wr -> store
    issue(1, 0, 2'b10, 0, 32'h040, 32'h0, 1);
    issue(1, 0, 2'b10, 0, 32'h044, 32'h0, 1);
    issue(0, 0, 2'b10, 0, 32'h048, 32'h0, 1);          // non-memory instruction
    issue(1, 0, 2'b01, 0, 32'h206, 32'h0, 2);          // reads back the SH

    // Random traffic.
    for (int t = 0; t < 120; t++) begin
      int lat;
      lat = $urandom_range(1, 5);
      if ($urandom_range(0, 9) == 0) lat = 0;
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), $urandom, lat);
    end

    // Reset while an access is outstanding.
    set_word(32'h080, 32'h0000_00C3);
    issue(1, 0, 2'b00, 1, 32'h080, 32'h0, 1);
    idle(1);
    chk("pre_reset_readdata", readdata_out, 32'h0000_00C3);
    issue(1, 0, 2'b10, 0, 32'h084, 32'h0, 0, 1);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk("busy_req_before_reset", 32'(dmem_bus.dmem_req), 32'(1'b1));
    reset = 1'b1;
    #1;
    chk("async_reset_req", 32'(dmem_bus.dmem_req), 32'(1'b0));
    chk("async_reset_stall", 32'(mem_stall), 32'(1'b0));
    chk("async_reset_readdata", readdata_out, 32'h0);
    exp_q.delete();
    last_rd = 32'h0;
    mem_rd = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    spur_ack = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #2;
    spur_ack = 1'b0;
    @(negedge clock);
    chk("late_ack_req", 32'(dmem_bus.dmem_req), 32'(1'b0));
    chk("late_ack_stall", 32'(mem_stall), 32'(1'b0));
    chk("late_ack_readdata", readdata_out, 32'h0);
    @(posedge clock);
    #2;
    issue(1, 0, 2'b01, 0, 32'h082, 32'h0, 3);
    idle(4);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
